// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the PicoRV32 memory bus arbiter
// Contents:
//   arb_state_t  - arbiter FSM encoding (ARB_IDLE, ARB_BUSY)
//   M_CPU/M_DMA  - master indices into grant/request vectors
//   DEF_ERR_DATA - default read word returned on a watchdog completion
package mem_arb_pkg;
    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;
    localparam int M_CPU = 0;
    localparam int M_DMA = 1;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;
endpackage

// File: rtl/rr_arbiter2.sv
// rr_arbiter2: combinational two-requester winner select, one-hot result
// Ports:
//   req        in  2  request vector, bit i = master i
//   last_grant in  1  index of the previous winner
//   gnt        out 2  one-hot winner, 00 when nothing requested
// Parameters:
//   FIXED_PRIO 0 = round-robin on ties, 1 = master 0 always wins ties
module rr_arbiter2
    import mem_arb_pkg::*;
#(
    parameter int FIXED_PRIO = 0
) (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] gnt
);
    // On a tie the master that did not win last time goes next, unless master 0 is pinned.
    always_comb begin
        gnt = req;
        if (req == 2'b11)
            gnt = (FIXED_PRIO != 0 || last_grant == 1'(M_DMA)) ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one RAM between CPU (master 0) and ADC DMA (master 1)
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   m0_*/m1_* valid/addr/wdata/wstrb in, ready/rdata out: native PicoRV32 master side
//   s_valid/s_addr/s_wdata/s_wstrb out, s_ready/s_rdata in: RAM side
//   grant        out  one-hot current owner, 00 when idle
//   timeout_err  out  one-cycle pulse when the watchdog ends a hung transfer
module mem_bus_arbiter
    import mem_arb_pkg::*;
#(
    parameter int                ADDR_W     = 32,
    parameter int                DATA_W     = 32,
    parameter int                TIMEOUT    = 255,
    parameter int                FIXED_PRIO = 0,
    parameter logic [DATA_W-1:0] ERR_DATA   = DATA_W'(DEF_ERR_DATA)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                m0_valid,
    input  logic [ADDR_W-1:0]   m0_addr,
    input  logic [DATA_W-1:0]   m0_wdata,
    input  logic [DATA_W/8-1:0] m0_wstrb,
    output logic                m0_ready,
    output logic [DATA_W-1:0]   m0_rdata,
    input  logic                m1_valid,
    input  logic [ADDR_W-1:0]   m1_addr,
    input  logic [DATA_W-1:0]   m1_wdata,
    input  logic [DATA_W/8-1:0] m1_wstrb,
    output logic                m1_ready,
    output logic [DATA_W-1:0]   m1_rdata,
    output logic                s_valid,
    output logic [ADDR_W-1:0]   s_addr,
    output logic [DATA_W-1:0]   s_wdata,
    output logic [DATA_W/8-1:0] s_wstrb,
    input  logic                s_ready,
    input  logic [DATA_W-1:0]   s_rdata,
    output logic [1:0]          grant,
    output logic                timeout_err
);
    localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    arb_state_t      state, state_nx;
    logic            owner, owner_nx;
    logic            last_grant, last_nx;
    logic [WD_W-1:0] wd_cnt, wd_nx;
    logic [1:0]      win;
    logic            busy, wd_fire, done;
    logic [DATA_W-1:0] rsp;

    rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
        .req        ({m1_valid, m0_valid}),
        .last_grant (last_grant),
        .gnt        (win)
    );

    assign busy    = state == ARB_BUSY;
    // A RAM completion in the threshold cycle beats the watchdog.
    assign wd_fire = busy && TIMEOUT != 0 && !s_ready && wd_cnt == WD_LAST;
    assign done    = busy && (s_ready || wd_fire);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ARB_IDLE;
            owner      <= 1'(M_CPU);
            last_grant <= 1'(M_DMA);
            wd_cnt     <= '0;
        end else begin
            state      <= state_nx;
            owner      <= owner_nx;
            last_grant <= last_nx;
            wd_cnt     <= wd_nx;
        end
    end

    // Arbitration only happens in IDLE, so every transfer is followed by a gap cycle.
    always_comb begin
        state_nx = state;
        owner_nx = owner;
        last_nx  = last_grant;
        wd_nx    = wd_cnt;
        if (!busy) begin
            if (|win) begin
                state_nx = ARB_BUSY;
                owner_nx = win[M_DMA];
                last_nx  = win[M_DMA];
                wd_nx    = '0;
            end
        end else if (done) begin
            state_nx = ARB_IDLE;
        end else begin
            wd_nx = (&wd_cnt) ? wd_cnt : wd_cnt + 1'b1;
        end
    end

    assign s_valid     = busy;
    assign s_addr      = busy ? (owner ? m1_addr  : m0_addr)  : '0;
    assign s_wdata     = busy ? (owner ? m1_wdata : m0_wdata) : '0;
    assign s_wstrb     = busy ? (owner ? m1_wstrb : m0_wstrb) : '0;
    assign grant       = {busy && owner, busy && !owner};
    assign rsp         = s_ready ? s_rdata : ERR_DATA;
    assign m0_ready    = done && !owner;
    assign m1_ready    = done && owner;
    assign m0_rdata    = m0_ready ? rsp : '0;
    assign m1_rdata    = m1_ready ? rsp : '0;
    assign timeout_err = wd_fire;
endmodule
